// File: rtl/encoder_alu_pkg.sv
// Shared ALU operation encoding: address type, one-hot select codes and the
// encode table used by both this encoder and the ALU decoder.
package encoder_alu_pkg;

   typedef logic [2:0] alu_addr_t;

   localparam logic [7:0] ALU_CODE_0 = 8'h00;
   localparam logic [7:0] ALU_CODE_1 = 8'h01;
   localparam logic [7:0] ALU_CODE_2 = 8'h02;
   localparam logic [7:0] ALU_CODE_3 = 8'h04;
   localparam logic [7:0] ALU_CODE_4 = 8'h08;
   localparam logic [7:0] ALU_CODE_5 = 8'h10;
   localparam logic [7:0] ALU_CODE_6 = 8'h20;
   localparam logic [7:0] ALU_CODE_7 = 8'h40;

   localparam alu_addr_t ALU_ADDR_INVALID = 3'd0;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      alu_addr_t addr;
      logic      err;
   } alu_entry_t;

   // 8'h80 and any multi-bit pattern fall through to the invalid entry.
   function automatic alu_entry_t encodeSel(input logic [7:0] sel);
      alu_entry_t e;
      e.addr = ALU_ADDR_INVALID;
      e.err  = 1'b0;
      case (sel)
         ALU_CODE_0: e.addr = 3'd0;
         ALU_CODE_1: e.addr = 3'd1;
         ALU_CODE_2: e.addr = 3'd2;
         ALU_CODE_3: e.addr = 3'd3;
         ALU_CODE_4: e.addr = 3'd4;
         ALU_CODE_5: e.addr = 3'd5;
         ALU_CODE_6: e.addr = 3'd6;
         ALU_CODE_7: e.addr = 3'd7;
         default:    e.err  = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/alu_skid_fifo2.sv
// Two-entry in-order buffer; pushReady depends only on registered state so
// the upstream never sees a combinational path from popReady.
module alu_skid_fifo2
   import encoder_alu_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pushValid_i,
   input  logic [DW-1:0] pushData_i,
   output logic          pushReady_o,
   output logic          popValid_o,
   output logic [DW-1:0] popData_o,
   input  logic          popReady_i
);

   occ_e          occ_q, occ_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] tail_q, tail_d;
   logic          readyEn_q;
   logic          doPush, doPop;

   // readyEn_q keeps pushReady low on the reset edge and raises it one edge later.
   assign pushReady_o = readyEn_q && (occ_q != OCC_FULL);
   assign popValid_o  = (occ_q != OCC_EMPTY);
   assign popData_o   = popValid_o ? head_q : '0;
   assign doPush      = pushValid_i && pushReady_o;
   assign doPop       = popValid_o && popReady_i;

   // Occupancy next-state and head/tail steering for push, pop or both.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (doPush) begin
               head_d = pushData_i;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (doPush && doPop) begin
               head_d = pushData_i;
            end else if (doPush) begin
               tail_d = pushData_i;
               occ_d  = OCC_FULL;
            end else if (doPop) begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (doPop) begin
               head_d = tail_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q     <= OCC_EMPTY;
         head_q    <= '0;
         tail_q    <= '0;
         readyEn_q <= 1'b0;
      end else begin
         occ_q     <= occ_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         readyEn_q <= 1'b1;
      end
   end

endmodule

// File: rtl/encoder_alu.sv
// One-hot ALU select encoder feeding a 2-entry buffer, with a saturating
// counter of accepted invalid select vectors.
module encoder_alu
   import encoder_alu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       sel_vec,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [2:0]       address,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   alu_entry_t        encoded;
   logic [3:0]        headBits;
   logic [CNT_W-1:0]  errCount_q, errCount_d;

   assign encoded = encodeSel(sel_vec);

   alu_skid_fifo2 #(
      .DW($bits(alu_entry_t))
   ) uFifo (
      .clk         (clk),
      .rst         (rst),
      .pushValid_i (in_valid),
      .pushData_i  (encoded),
      .pushReady_o (in_ready),
      .popValid_o  (out_valid),
      .popData_o   (headBits),
      .popReady_i  (out_ready)
   );

   assign address   = headBits[3:1];
   assign err       = headBits[0];
   assign err_count = errCount_q;

   // Count only invalid codes that are actually accepted; stick at the maximum.
   always_comb begin
      errCount_d = errCount_q;
      if (in_valid && in_ready && encoded.err && (errCount_q != CNT_MAX)) begin
         errCount_d = errCount_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         errCount_q <= '0;
      end else begin
         errCount_q <= errCount_d;
      end
   end

endmodule

// File: tb/tb_encoder_alu.sv
// Directed bench for encoder_alu: encode table, flow control, ordering,
// counter saturation and mid-operation reset.
module tb_encoder_alu;

   logic       clk;
   logic       rst;
   logic [7:0] selVec;
   logic       inValid, inReady, outValid, outReady, errO;
   logic [2:0] address;
   logic [7:0] errCount;

   logic [7:0] selVecB;
   logic       inValidB, inReadyB, outValidB, outReadyB, errB;
   logic [2:0] addressB;
   logic [1:0] errCountB;

   int checks = 0;
   int errors = 0;

   logic [7:0] codes [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

   encoder_alu #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .sel_vec(selVec), .in_valid(inValid),
      .in_ready(inReady), .address(address), .err(errO),
      .out_valid(outValid), .out_ready(outReady), .err_count(errCount)
   );

   encoder_alu #(.CNT_W(2)) dutB (
      .clk(clk), .rst(rst), .sel_vec(selVecB), .in_valid(inValidB),
      .in_ready(inReadyB), .address(addressB), .err(errB),
      .out_valid(outValidB), .out_ready(outReadyB), .err_count(errCountB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; selVec = 8'h00; inValid = 1'b0; outReady = 1'b0;
      selVecB = 8'h00; inValidB = 1'b0; outReadyB = 1'b0;

      // Reset state
      applyStimulus();
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_address", address, 0);
      checkOutput("rst_err", errO, 0);
      checkOutput("rst_in_ready", inReady, 0);
      checkOutput("rst_err_count", errCount, 0);
      rst = 1'b0;
      applyStimulus();
      checkOutput("post_rst_in_ready", inReady, 1);
      checkOutput("post_rst_out_valid", outValid, 0);

      // All valid codes back-to-back with the consumer always ready
      outReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         selVec = codes[i]; inValid = 1'b1;
         applyStimulus();
         checkOutput($sformatf("seq_valid_%0d", i), outValid, 1);
         checkOutput($sformatf("seq_addr_%0d", i), address, i);
         checkOutput($sformatf("seq_err_%0d", i), errO, 0);
      end
      inValid = 1'b0;
      applyStimulus();
      checkOutput("seq_drain_valid", outValid, 0);
      checkOutput("seq_drain_addr", address, 0);

      // Invalid codes
      selVec = 8'h80; inValid = 1'b1;
      applyStimulus();
      checkOutput("inv80_addr", address, 0);
      checkOutput("inv80_err", errO, 1);
      selVec = 8'h03;
      applyStimulus();
      checkOutput("inv03_err", errO, 1);
      checkOutput("inv03_valid", outValid, 1);
      inValid = 1'b0;
      applyStimulus();
      checkOutput("inv_err_count", errCount, 2);
      checkOutput("inv_drain_err", errO, 0);

      // Backpressure: third push held off, head stable, order kept
      outReady = 1'b0; inValid = 1'b1; selVec = 8'h01;
      applyStimulus();
      checkOutput("bp_ready_1", inReady, 1);
      checkOutput("bp_head_1", address, 1);
      selVec = 8'h02;
      applyStimulus();
      checkOutput("bp_ready_2", inReady, 0);
      checkOutput("bp_head_2", address, 1);
      selVec = 8'h04;
      applyStimulus();
      checkOutput("bp_head_3", address, 1);
      applyStimulus();
      checkOutput("bp_head_4", address, 1);
      checkOutput("bp_ready_4", inReady, 0);
      inValid = 1'b0; outReady = 1'b1;
      applyStimulus();
      checkOutput("bp_pop1_addr", address, 2);
      checkOutput("bp_pop1_ready", inReady, 1);
      applyStimulus();
      checkOutput("bp_pop2_valid", outValid, 0);

      // Simultaneous push/pop at occupancy ONE for 20 cycles
      outReady = 1'b0; inValid = 1'b1; selVec = codes[1];
      applyStimulus();
      checkOutput("pp_prime_addr", address, 1);
      outReady = 1'b1;
      for (int k = 0; k < 20; k++) begin
         selVec = codes[(k + 2) % 8];
         applyStimulus();
         checkOutput($sformatf("pp_addr_%0d", k), address, (k + 2) % 8);
         checkOutput($sformatf("pp_ready_%0d", k), inReady, 1);
         checkOutput($sformatf("pp_valid_%0d", k), outValid, 1);
      end
      inValid = 1'b0;
      applyStimulus();
      checkOutput("pp_drain_valid", outValid, 0);

      // Bring err_count to 5, fill, then reset with a colliding transfer
      selVec = 8'hFF; inValid = 1'b1;
      for (int j = 0; j < 3; j++) applyStimulus();
      inValid = 1'b0;
      applyStimulus();
      checkOutput("pre_rst_count", errCount, 5);
      outReady = 1'b0; inValid = 1'b1; selVec = 8'h08;
      applyStimulus();
      selVec = 8'h10;
      applyStimulus();
      checkOutput("pre_rst_full", inReady, 0);
      checkOutput("pre_rst_head", address, 4);
      rst = 1'b1; selVec = 8'hC0; outReady = 1'b1;
      applyStimulus();
      checkOutput("mid_rst_valid", outValid, 0);
      checkOutput("mid_rst_count", errCount, 0);
      checkOutput("mid_rst_ready", inReady, 0);
      checkOutput("mid_rst_addr", address, 0);
      rst = 1'b0; inValid = 1'b0;
      applyStimulus();
      checkOutput("after_rst_ready", inReady, 1);
      checkOutput("after_rst_valid", outValid, 0);
      applyStimulus();
      checkOutput("after_rst_stale", outValid, 0);

      // Offers without in_valid change nothing
      selVec = 8'hFF; inValid = 1'b0;
      applyStimulus();
      checkOutput("idle_count", errCount, 0);
      checkOutput("idle_valid", outValid, 0);

      // Narrow counter saturates
      selVecB = 8'h80; inValidB = 1'b1; outReadyB = 1'b1;
      for (int j = 0; j < 3; j++) applyStimulus();
      checkOutput("sat_count_3", errCountB, 3);
      for (int j = 0; j < 2; j++) applyStimulus();
      inValidB = 1'b0;
      applyStimulus();
      checkOutput("sat_count_5", errCountB, 3);
      applyStimulus();
      checkOutput("sat_hold", errCountB, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
